hazard_tracker: RTL and testbench

Consumer end of the decode stage's Tuse/Tnew hazard interface in the 5-stage MIPS pipeline. It takes each decoded instruction's source registers, Tuse, destination and Tnew, and tracks in-flight writers through E/M/W in an internal scoreboard pipeline. From that it produces the D-stage stall and the forwarding selects for the D-stage (branch compare/jr) and E-stage (ALU) operands.

---
 rtl/hazard_tracker.sv | 153 +++++++++++++++
 tb/tb_hazard_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// hazard_tracker: D-stage hazard unit for a 5-stage MIPS pipeline.
// Tracks in-flight register writers through E/M/W using each instruction's
// Tnew, and compares them against the D-stage sources and their Tuse.
// From that it produces the D-stage stall and the D/E forwarding selects.
// Optional feature macro: STALL_COUNT_EN (adds stall_cnt, a saturating
// count of stall cycles).
module hazard_tracker #(
    parameter int unsigned RAW = 5,
    parameter int unsigned TW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [RAW-1:0] rs_D,
    input  logic [RAW-1:0] rt_D,
    input  logic [TW-1:0]  rsTuse_D,
    input  logic [TW-1:0]  rtTuse_D,
    input  logic [RAW-1:0] dst_D,
    input  logic [TW-1:0]  Tnew_D,
    input  logic           RegWrite_D,
    output logic           stall,
    output logic [1:0]     fwd_rs_D,
    output logic [1:0]     fwd_rt_D,
    output logic [1:0]     fwd_rs_E,
    output logic [1:0]     fwd_rt_E
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);

    // Tuse value meaning "operand not read"
    localparam logic [TW-1:0] TUSE_NONE = '1;

    localparam logic [1:0] SRC_RF = 2'd0;
    localparam logic [1:0] SRC_E  = 2'd1;
    localparam logic [1:0] SRC_M  = 2'd2;
    localparam logic [1:0] SRC_W  = 2'd3;

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] dst;
        logic [TW-1:0]  tnew;
    } writer_t;

    typedef struct packed {
        writer_t        w;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
    } e_entry_t;

    e_entry_t       e_q, e_d;
    writer_t        m_q, m_d;
    // W results are always settled, so only valid and dst are kept there
    logic           w_valid_q, w_valid_d;
    logic [RAW-1:0] w_dst_q, w_dst_d;

    logic stall_rs, stall_rt;

    // Qualifying writer: valid, not $0, and targeting the requested register
    function automatic logic hit(input logic v, input logic [RAW-1:0] d,
                                 input logic [RAW-1:0] r);
        return v && (d != '0) && (d == r);
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    function automatic logic src_stall(input writer_t e, input writer_t m,
                                       input logic [RAW-1:0] r,
                                       input logic [TW-1:0] tuse);
        return (tuse != TUSE_NONE) && (r != '0) &&
               ((hit(e.valid, e.dst, r) && (e.tnew > tuse)) ||
                (hit(m.valid, m.dst, r) && (m.tnew > tuse)));
    endfunction

    // Newest matching writer decides; a not-ready one blocks older sources
    function automatic logic [1:0] sel_d(input writer_t e, input writer_t m,
                                         input logic wv, input logic [RAW-1:0] wd,
                                         input logic [RAW-1:0] r);
        if (hit(e.valid, e.dst, r)) return (e.tnew == '0) ? SRC_E : SRC_RF;
        if (hit(m.valid, m.dst, r)) return (m.tnew == '0) ? SRC_M : SRC_RF;
        if (hit(wv, wd, r))         return SRC_W;
        return SRC_RF;
    endfunction

    function automatic logic [1:0] sel_e(input writer_t m, input logic wv,
                                         input logic [RAW-1:0] wd,
                                         input logic [RAW-1:0] r);
        if (hit(m.valid, m.dst, r)) return (m.tnew == '0) ? SRC_M : SRC_RF;
        if (hit(wv, wd, r))         return SRC_W;
        return SRC_RF;
    endfunction

    // Combinational stall and forwarding selects
    always_comb begin
        stall_rs = src_stall(e_q.w, m_q, rs_D, rsTuse_D);
        stall_rt = src_stall(e_q.w, m_q, rt_D, rtTuse_D);
        stall    = stall_rs | stall_rt;
        fwd_rs_D = sel_d(e_q.w, m_q, w_valid_q, w_dst_q, rs_D);
        fwd_rt_D = sel_d(e_q.w, m_q, w_valid_q, w_dst_q, rt_D);
        fwd_rs_E = sel_e(m_q, w_valid_q, w_dst_q, e_q.rs);
        fwd_rt_E = sel_e(m_q, w_valid_q, w_dst_q, e_q.rt);
    end

    // Scoreboard next state: advance one stage, bubble into E on stall
    always_comb begin
        m_d.valid = e_q.w.valid;
        m_d.dst   = e_q.w.dst;
        m_d.tnew  = dec_sat(e_q.w.tnew);
        w_valid_d = m_q.valid;
        w_dst_d   = m_q.dst;
        e_d       = '0;
        if (!stall) begin
            e_d.w.valid = RegWrite_D;
            e_d.w.dst   = dst_D;
            e_d.w.tnew  = Tnew_D;
            e_d.rs      = rs_D;
            e_d.rt      = rt_D;
        end
    end

    // Scoreboard registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_valid_q <= 1'b0;
            w_dst_q   <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_valid_q <= w_valid_d;
            w_dst_q   <= w_dst_d;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed testbench for hazard_tracker; build with +define+STALL_COUNT_EN
// to also cover the stall counter.
module tb_hazard_tracker;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D, rt_D, dst_D;
    logic [1:0] rsTuse_D, rtTuse_D, Tnew_D;
    logic       RegWrite_D;
    logic       stall;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .rsTuse_D   (rsTuse_D),
        .rtTuse_D   (rtTuse_D),
        .dst_D      (dst_D),
        .Tnew_D     (Tnew_D),
        .RegWrite_D (RegWrite_D),
        .stall      (stall),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] rsu, input logic [1:0] rtu,
                         input logic [4:0] dst, input logic [1:0] tn,
                         input logic rw);
        rs_D = rs; rt_D = rt; rsTuse_D = rsu; rtTuse_D = rtu;
        dst_D = dst; Tnew_D = tn; RegWrite_D = rw;
        #1;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
    endtask

    task automatic flush();
        nop();
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(5'd5, 5'd6, 2'd0, 2'd0, 5'd5, 2'd2, 1'b1);
        tick(); tick();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        n_cmp++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'h00) begin n_err++;
            $display("FAIL reset_fwd got=%h exp=00", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}); end
`ifdef STALL_COUNT_EN
        n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
`endif
        nop();
        reset = 1'b1;
        tick();
    endtask

    // lw $2 ; addu rs=$2 (Tuse 1)
    task automatic test_load_use();
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd2, 2'd2, 1'b1);
        tick();
        drive(5'd2, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b1);
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL loaduse_stall1 got=%0b exp=1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL loaduse_stall2 got=%0b exp=0", stall); end
        tick();
        nop();
        n_cmp++; if (fwd_rs_E !== 2'd3) begin n_err++; $display("FAIL loaduse_fwdE got=%0d exp=3", fwd_rs_E); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL loaduse_stall3 got=%0b exp=0", stall); end
        flush();
    endtask

    // addu $3 ; beq rs=$3 (Tuse 0)
    task automatic test_branch_alu();
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd3, 2'd1, 1'b1);
        tick();
        drive(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL branch_stall1 got=%0b exp=1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL branch_stall2 got=%0b exp=0", stall); end
        n_cmp++; if (fwd_rs_D !== 2'd2) begin n_err++; $display("FAIL branch_fwdD got=%0d exp=2", fwd_rs_D); end
        flush();
    endtask

    // jal ; jr $31
    task automatic test_jal_jr();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b1);
        tick();
        drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL jr_stall got=%0b exp=0", stall); end
        n_cmp++; if (fwd_rs_D !== 2'd1) begin n_err++; $display("FAIL jr_fwdD got=%0d exp=1", fwd_rs_D); end
        flush();
    endtask

    // addu $4 ; lw $4 ; addu rs=$4 (Tuse 1)
    task automatic test_double_writer();
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd4, 2'd1, 1'b1);
        tick();
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd4, 2'd2, 1'b1);
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL dbl_stall0 got=%0b exp=0", stall); end
        tick();
        drive(5'd4, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 1'b1);
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL dbl_stall1 got=%0b exp=1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL dbl_stall2 got=%0b exp=0", stall); end
        n_cmp++; if (fwd_rs_D !== 2'd0) begin n_err++; $display("FAIL dbl_block got=%0d exp=0", fwd_rs_D); end
        tick();
        nop();
        n_cmp++; if (fwd_rs_E !== 2'd3) begin n_err++; $display("FAIL dbl_fwdE got=%0d exp=3", fwd_rs_E); end
        flush();
    endtask

    // lw $0 ; addu rs=$0, and an unused operand matching a load
    task automatic test_zero_dst();
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b1);
        tick();
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd11, 2'd1, 1'b1);
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall got=%0b exp=0", stall); end
        tick();
        nop();
        n_cmp++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'h00) begin n_err++;
            $display("FAIL zero_fwd got=%h exp=00", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}); end
        flush();
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 1'b1);
        tick();
        drive(5'd8, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL nouse_stall got=%0b exp=0", stall); end
        flush();
    endtask

    // addu $5 ; sw-like rt=$5 (Tuse 1): E-stage forward from M on rt
    task automatic test_rt_fwd_m();
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd5, 2'd1, 1'b1);
        tick();
        drive(5'd0, 5'd5, 2'd3, 2'd1, 5'd0, 2'd0, 1'b0);
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rtm_stall got=%0b exp=0", stall); end
        n_cmp++; if (fwd_rt_D !== 2'd0) begin n_err++; $display("FAIL rtm_fwdD got=%0d exp=0", fwd_rt_D); end
        tick();
        nop();
        n_cmp++; if (fwd_rt_E !== 2'd2) begin n_err++; $display("FAIL rtm_fwdE got=%0d exp=2", fwd_rt_E); end
        n_cmp++; if (fwd_rs_E !== 2'd0) begin n_err++; $display("FAIL rtm_rsE got=%0d exp=0", fwd_rs_E); end
        flush();
    endtask

    // lw $7 ; addu rs=$7 stalls, reset applied during the stall
    task automatic test_reset_mid_stall();
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd7, 2'd2, 1'b1);
        tick();
        drive(5'd7, 5'd7, 2'd1, 2'd1, 5'd12, 2'd1, 1'b1);
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got=%0b exp=1", stall); end
        reset = 1'b0;
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got=%0b exp=0", stall); end
        n_cmp++; if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'h00) begin n_err++;
            $display("FAIL rst_mid_fwd got=%h exp=00", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}); end
`ifdef STALL_COUNT_EN
        n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
`endif
        reset = 1'b1;
        nop();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        rs_D = '0; rt_D = '0; rsTuse_D = 2'd3; rtTuse_D = 2'd3;
        dst_D = '0; Tnew_D = '0; RegWrite_D = 1'b0;
        test_reset();
        test_load_use();
        test_branch_alu();
        test_jal_jr();
        test_double_writer();
        test_zero_dst();
        test_rt_fwd_m();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
